// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU state encoding and request legality helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Stores only come in byte/half/word; loads additionally have the unsigned variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
    else
      return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  // Low two funct3 bits give the access size for every legal encoding.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store byte enables / replication and load lane select / extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] word_addr,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halves/words simply drop the offending low bits.
  always_comb begin
    off = addr[1:0];
    case (funct3[1:0])
      2'b01:   off = {addr[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr[1:0];
    endcase
  end

  assign word_addr = {addr[31:2], 2'b00};

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    store_data = 32'h0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          be         = 4'b0001 << off;
          store_data = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be         = 4'b0011 << off;
          store_data = {2{wdata[15:0]}};
        end
        F3_SW: begin
          be         = 4'b1111;
          store_data = wdata;
        end
        default: begin
          be         = 4'b0000;
          store_data = 32'h0;
        end
      endcase
    end else begin
      be = 4'b1111;
    end
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time over a ready-handshaked memory port, with timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
module lsu
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        illegal;
  logic        timeout;
  logic [31:0] word_addr;
  logic [3:0]  be;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign accept  = req_valid && (state == ST_IDLE);
  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign illegal = f3_illegal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign illegal = f3_illegal(req_we, req_funct3);
`endif

  lsu_align u_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .word_addr  (word_addr),
    .be         (be),
    .store_data (store_data),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = illegal ? ST_RESP : ST_MEM;
      ST_MEM:  if (mem_ready || timeout) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, timeout counting and response latching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= illegal;
            rdata_q  <= 32'h0;
            cnt      <= '0;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            rdata_q <= we_q ? 32'h0 : load_data;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    if (state == ST_MEM) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = word_addr;
      mem_be    = be;
      mem_wdata = store_data;
    end
    if (state == ST_RESP) begin
      rsp_valid = 1'b1;
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: max cycles in MEM awaiting mem_ready before abort.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1  access request from execute stage.
REQ-005 SHALL have ports: req_ready  out  1  LSU can accept a request.
REQ-006 SHALL have ports: req_we  in  1  1=store, 0=load.
REQ-007 SHALL have ports: req_addr  in  32  effective address (ALU res).
REQ-008 SHALL have ports: req_funct3  in  3  RV32I width/sign code.
REQ-009 SHALL have ports: req_wdata  in  32  store data (rs2).
REQ-010 SHALL have ports: mem_req  out  1  memory access strobe.
REQ-011 SHALL have ports: mem_we  out  1  memory write.
REQ-012 SHALL have ports: mem_addr  out  32  word-aligned address, bits[1:0]=00.
REQ-013 SHALL have ports: mem_be  out  4  byte enables.
REQ-014 SHALL have ports: mem_wdata  out  32  lane-replicated store data.
REQ-015 SHALL have ports: mem_ready  in  1  memory completed access this cycle.
REQ-016 SHALL have ports: mem_rdata  in  32  read word, valid with mem_ready.
REQ-017 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse.
REQ-018 SHALL have ports: rsp_rdata  out  32  extended load result; 0 for stores/errors.
REQ-019 SHALL have ports: rsp_err  out  1  access failed (valid with rsp_valid).

Function
REQ-020 SHALL implement FSM IDLE, MEM, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL capture req_* on req_valid&&req_ready; IDLE->MEM, or IDLE->RESP with rsp_err=1 if request illegal.
REQ-022 SHALL treat as illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
REQ-023 SHALL hold mem_req=1 and all mem_* stable throughout MEM until mem_ready.
REQ-024 SHALL go MEM->RESP on mem_ready; latency: accept edge N, mem_req from N+1, mem_ready at N+1 gives rsp_valid at N+2.
REQ-025 SHALL count MEM cycles; on reaching TIMEOUT_CYC without mem_ready, drop mem_req, go RESP, rsp_err=1.
REQ-026 SHALL assert rsp_valid exactly one cycle in RESP, then return to IDLE; no back-pressure on rsp.
REQ-027 SHALL for stores drive mem_be: SB 0001<<addr[1:0], SH 0011<<(addr[1]*2), SW 1111; mem_wdata byte replicated (SB), half replicated (SH), whole word (SW).
REQ-028 SHALL for loads drive mem_be=1111, select lane by addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU, pass LW unchanged.
REQ-029 SHALL ignore mem_ready outside MEM.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge force IDLE, clear timeout counter, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, regardless of in-flight access.
REQ-031 SHALL assert req_ready=1 the cycle after reset releases; an aborted access produces no rsp_valid.

Configuration
REQ-032 SHALL with LSU_MISALIGN_TRAP_EN defined flag LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=00 as illegal: no mem_req, RESP with rsp_err=1.
REQ-033 SHALL without LSU_MISALIGN_TRAP_EN clear offending low address bits (half: bit0, word: bits1:0) and complete the access normally, rsp_err=0.

Structure
REQ-034 SHALL place funct3 encodings (LB..LHU, SB..SW) and FSM state encoding in shared package rv32i_pkg.
REQ-035 SHALL implement lane select/extension and byte-enable/replication in combinational sub-module lsu_align.

Verification
REQ-036 SHALL test LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready at N+1 -> rsp_valid at N+2, rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-037 SHALL test LB addr 0x103, mem_rdata 0x80FF0000 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SHALL test SH addr 0x202, wdata 0x1234ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-039 SHALL test LW addr 0x101 -> with macro: no mem_req, rsp_err 1; without: mem_addr 0x100, rsp_err 0.
REQ-040 SHALL test mem_ready held 0 -> after 16 MEM cycles rsp_valid with rsp_err 1, mem_req low.
REQ-041 SHALL test rst_n low mid-MEM -> next edge mem_req 0, no rsp_valid, req_ready 1 after release.
